// File: rtl/uart_tx.sv
// uart_tx: reports a result byte as two ASCII hex digits and a CR
// on an 8N1 serial line paced by a 16x-baud tick strobe.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int NCHAR   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en_tx,
  input  logic [7:0] res,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int CW   = (NCHAR > 1) ? $clog2(NCHAR) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [CW-1:0]     c_q, c_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic [7:0]        res_q, res_d;
  logic              tx_q, tx_d;
  logic              en_q;
  logic              armed_q;
  logic              rise;
  logic [7:0]        ch;

  function automatic logic [7:0] hex(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'd0, v};
    return 8'h37 + {4'd0, v};
  endfunction

  // armed blocks a level already high at reset release from
  // being taken as a request
  assign rise = en_tx & ~en_q & armed_q;

  // character c of the message
  always_comb begin
    ch = 8'h0D;
    unique case (1'b1)
      (c_q == CW'(0)): ch = hex(res_q[7:4]);
      (c_q == CW'(1)): ch = hex(res_q[3:0]);
      default:         ch = 8'h0D;
    endcase
  end

  // next-state and datapath updates; only tick advances framing
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    c_d     = c_q;
    shift_d = shift_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          res_d   = res;
          s_d     = '0;
          n_d     = '0;
          c_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            shift_d = DBIT'(ch);
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d = '0;
            if (c_q < CW'(NCHAR - 1)) begin
              c_d     = c_q + CW'(1);
              state_d = START;
            end else begin
              state_d = DONE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // line level follows the state being entered
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // state, datapath and registered line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      c_q     <= '0;
      shift_q <= '0;
      res_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      c_q     <= c_d;
      shift_q <= shift_d;
      res_q   <= res_d;
      tx_q    <= tx_d;
    end
  end

  // request edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      en_q    <= en_tx;
      armed_q <= armed_q | ~en_tx;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The parameter list SHALL be, one per line: name, default, meaning.
- DBIT, 8, data bits per character.
- SB_TICK, 16, ticks per stop bit.
- NCHAR, 3, characters per message.

REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- tick, input, 1, 16x-baud sample strike, one clk wide.
- en_tx, input, 1, level request to send.
- res, input, 8, result byte to report.
- tx, output, 1, serial line; idles high.
- busy, output, 1, high while a message is in progress.
- done, output, 1, one-clk pulse when a message completes.

Function
REQ-003 A message SHALL be NCHAR characters, sent in this order:
- ASCII hex of res[7:4].
- ASCII hex of res[3:0].
- 0x0D (CR).

REQ-004 Hex encoding SHALL map nibble n to 0x30+n for n=0..9 and to 0x41+(n-10) for n=10..15.

REQ-005 Each character SHALL be framed 8N1:
- one start bit (0) of 16 ticks;
- DBIT data bits, LSB first, 16 ticks each;
- one stop bit (1) of SB_TICK ticks.

REQ-006 The state machine SHALL have five states: IDLE, START, DATA, STOP, DONE.

REQ-007 IDLE: a rising edge of en_tx (en_tx=1 and its previous-clk sample=0) SHALL:
- latch res into an internal register;
- clear the tick counter s, bit counter n and character index c;
- move to START on the next clk.

REQ-008 START: tx SHALL be 0. On a tick with s==15: clear s, load the shift register with character c, clear n, go to DATA. Otherwise a tick SHALL increment s.

REQ-009 DATA: tx SHALL equal shift[0]. On a tick with s==15:
- clear s and shift right by one;
- if n==DBIT-1 go to STOP, else increment n.

REQ-010 STOP: tx SHALL be 1. On a tick with s==SB_TICK-1:
- if c<NCHAR-1, increment c and go to START, with no idle gap;
- else go to DONE.

REQ-011 DONE SHALL last exactly one clk, assert done=1 for that clk, and return to IDLE.

REQ-012 Clk cycles with tick=0 SHALL leave s, n, c, the shift register and the state unchanged. The IDLE edge detect and DONE are the only tick-independent actions.

REQ-013 tx SHALL be registered: it changes on the same clk edge as the state and is glitch-free.

REQ-014 busy SHALL be 1 in START, DATA, STOP and DONE, and 0 in IDLE.

REQ-015 Timing for one message:
- tx SHALL fall one clk after the en_tx rising edge is sampled.
- Total duration SHALL be NCHAR*(16*(DBIT+1)+SB_TICK) ticks.

REQ-016 An en_tx rising edge while busy=1 SHALL be ignored and SHALL NOT be queued.

REQ-017 res changes after latching SHALL NOT affect the message in flight.

REQ-018 en_tx held high after a message SHALL NOT start another message; a new message needs en_tx to return to 0 and rise again.

REQ-019 An en_tx rising edge in the same clk as done=1 SHALL be ignored.

Reset
REQ-020 While rst=0, the block SHALL hold:
- state=IDLE, tx=1, busy=0, done=0;
- s, n, c, shift register, latched res and the en_tx sample all 0.

REQ-021 Reset asserted mid-character SHALL force tx=1 asynchronously, with no partial stop bit. After release, the block SHALL wait for a fresh en_tx rising edge.

REQ-022 If en_tx is already 1 when rst releases, no message SHALL start until en_tx falls and rises again.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- res=0x3A, en_tx 0->1, tick every 4 clk -> decoded serial bytes 0x33, 0x41, 0x0D; busy high for 3*160*4 clk; a single done pulse.
- res=0xF0 -> bytes 0x46, 0x30, 0x0D; the start bit of character 0 sampled low at tick 8; each stop bit high for 16 ticks.
- Second en_tx pulse and a change of res to 0x55 during character 1 -> message unchanged; exactly one done; no second message follows.
- en_tx held high for 2 message durations -> exactly one message; tx stays high after done.
- rst=0 in the DATA state of character 1 -> tx=1 and busy=0 within the same clk; a new en_tx edge after release gives a complete 3-byte message.
- tick held at 0 for 100 clk mid-bit -> tx and the state are frozen; the bit resumes with its remaining tick count.
